// File: rtl/lzc_dichotomy_pipe.sv
// Pipelined leading-zero/one counter built from an OR-reduce dichotomy tree.
// Tree levels are spread over PIPE_STAGES elastic register stages.
module lzc_dichotomy_pipe #(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4,
    parameter int CNT_W       = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LOG   = CNT_W - 1;
    localparam int P     = PIPE_STAGES;
    localparam int BASE  = LOG / P;
    localparam int EXTRA = LOG % P;

    logic [WIDTH-1:0] win_q  [P];
    logic [WIDTH-1:0] win_in [P];
    logic [WIDTH-1:0] win_d  [P];
    logic [LOG-1:0]   cnt_q  [P];
    logic [LOG-1:0]   cnt_in [P];
    logic [LOG-1:0]   cnt_d  [P];
    logic [TAG_W-1:0] tag_q  [P];
    logic [TAG_W-1:0] tag_in [P];
    logic [P-1:0]     vld_q;
    logic [P-1:0]     adv;
    logic [P-1:0]     load;
    logic [P:0]       go;

    // go[s]: stage s can take a word this cycle (empty or draining)
    always_comb begin
        adv   = '0;
        go    = '0;
        go[P] = out_ready;
        for (int s = P - 1; s >= 0; s--) begin
            adv[s] = vld_q[s] & go[s+1];
            go[s]  = ~vld_q[s] | adv[s];
        end
    end

    assign in_ready = ~rst & go[0];

    for (genvar s = 0; s < P; s++) begin : g_stage
        localparam int NL = BASE + ((s < EXTRA) ? 1 : 0);
        localparam int L0 = s * BASE + ((s < EXTRA) ? s : EXTRA);

        logic [WIDTH-1:0] w;
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
        logic [WIDTH-1:0] mask;
        logic [LOG-1:0]   c;
        int               half;

        if (s == 0) begin : g_entry
            assign win_in[s] = in_mode ? ~in_data : in_data;
            assign cnt_in[s] = '0;
            assign tag_in[s] = in_tag;
            assign load[s]   = in_valid & in_ready;
        end else begin : g_link
            assign win_in[s] = win_q[s-1];
            assign cnt_in[s] = cnt_q[s-1];
            assign tag_in[s] = tag_q[s-1];
            assign load[s]   = adv[s-1];
        end

        // Window lives in the low bits and halves at every level
        always_comb begin
            w    = win_in[s];
            c    = cnt_in[s];
            hi   = '0;
            lo   = '0;
            mask = '0;
            half = 0;
            for (int k = 1; k <= LOG; k++) begin
                if (k > L0 && k <= L0 + NL) begin
                    half = WIDTH >> k;
                    mask = (WIDTH'(1) << half) - WIDTH'(1);
                    hi   = (w >> half) & mask;
                    lo   = w & mask;
                    c    = c | (LOG'(hi == '0) << (LOG - k));
                    w    = (hi != '0) ? hi : lo;
                end
            end
            win_d[s] = w;
            cnt_d[s] = c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int s = 0; s < P; s++) begin
                win_q[s] <= '0;
                cnt_q[s] <= '0;
                tag_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < P; s++) begin
                vld_q[s] <= load[s] | (vld_q[s] & ~adv[s]);
                if (load[s]) begin
                    win_q[s] <= win_d[s];
                    cnt_q[s] <= cnt_d[s];
                    tag_q[s] <= tag_in[s];
                end
            end
        end
    end

    assign out_valid = vld_q[P-1];
    assign out_zero  = vld_q[P-1] & ~|win_q[P-1];
    assign out_count = out_zero ? CNT_W'(WIDTH) : {1'b0, cnt_q[P-1]};
    assign out_tag   = tag_q[P-1];

endmodule

// File: tb/tb_lzc_dichotomy_pipe.sv
// Bench for lzc_dichotomy_pipe: directed checks on a 32-bit/2-stage instance
// plus mixed sweeps on 8-bit/1-stage and 64-bit/6-stage instances.
module tb_lzc_dichotomy_pipe;

    typedef struct {
        int         cnt;
        bit         z;
        logic [3:0] tag;
    } exp_t;

    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    logic        a_in_valid = 0, a_in_ready, a_in_mode = 0;
    logic [31:0] a_in_data = 0;
    logic [3:0]  a_in_tag = 0, a_out_tag;
    logic        a_out_valid, a_out_ready = 1, a_out_zero;
    logic [5:0]  a_out_count;

    logic        b_in_valid = 0, b_in_ready, b_in_mode = 0;
    logic [7:0]  b_in_data = 0;
    logic [3:0]  b_in_tag = 0, b_out_tag;
    logic        b_out_valid, b_out_ready = 1, b_out_zero;
    logic [3:0]  b_out_count;

    logic        c_in_valid = 0, c_in_ready, c_in_mode = 0;
    logic [63:0] c_in_data = 0;
    logic [3:0]  c_in_tag = 0, c_out_tag;
    logic        c_out_valid, c_out_ready = 1, c_out_zero;
    logic [6:0]  c_out_count;

    lzc_dichotomy_pipe #(.WIDTH(32), .PIPE_STAGES(2), .TAG_W(4)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_mode(a_in_mode), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_count(a_out_count), .out_zero(a_out_zero), .out_tag(a_out_tag)
    );

    lzc_dichotomy_pipe #(.WIDTH(8), .PIPE_STAGES(1), .TAG_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_mode(b_in_mode), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_count(b_out_count), .out_zero(b_out_zero), .out_tag(b_out_tag)
    );

    lzc_dichotomy_pipe #(.WIDTH(64), .PIPE_STAGES(6), .TAG_W(4)) dut_c (
        .clk(clk), .rst(rst),
        .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_mode(c_in_mode), .in_tag(c_in_tag),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_count(c_out_count), .out_zero(c_out_zero), .out_tag(c_out_tag)
    );

    int checks = 0;
    int errors = 0;
    int nb = 0;
    int nc = 0;
    int k;
    exp_t qa[$], qb[$], qc[$];
    exp_t dummy;
    logic [3:0] log_a[$];

    logic [31:0] v_d [6] = '{32'h8000_0000, 32'h0000_0001, 32'h00F0_0000,
                             32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_0000};
    bit          v_m [6] = '{0, 0, 0, 0, 1, 1};
    int          v_c [6] = '{0, 31, 8, 32, 32, 16};
    bit          v_z [6] = '{0, 0, 0, 1, 1, 0};
    logic [31:0] t3_d [4] = '{32'h0000_8000, 32'h4000_0000,
                              32'h0000_0003, 32'h0000_0000};

    function automatic int ref_lzc(logic [63:0] d, bit m, int w);
        for (int i = w - 1; i >= 0; i--)
            if (d[i] ^ m) return w - 1 - i;
        return w;
    endfunction

    function automatic exp_t mk(logic [63:0] d, bit m, logic [3:0] t, int w);
        exp_t e;
        e.cnt = ref_lzc(d, m, w);
        e.z   = (e.cnt == w);
        e.tag = t;
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic cmp(input string nm, input bit have, input int cnt,
                       input logic z, input logic [3:0] tag, input exp_t e);
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL %s_unexpected actual=valid required=idle", nm);
        end else begin
            chk({nm, "_cnt"}, cnt, e.cnt);
            chk({nm, "_zero"}, int'(z), int'(e.z));
            chk({nm, "_tag"}, int'(tag), int'(e.tag));
        end
    endtask

    // Scoreboard: transfers decided at the next rising edge are sampled here
    always @(negedge clk) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            qc.delete();
        end else begin
            if (a_out_valid) begin
                cmp("a", qa.size() != 0, int'(a_out_count), a_out_zero,
                    a_out_tag, qa.size() != 0 ? qa[0] : dummy);
                if (a_out_ready && qa.size() != 0) begin
                    log_a.push_back(a_out_tag);
                    void'(qa.pop_front());
                end
            end
            if (a_in_valid && a_in_ready)
                qa.push_back(mk(64'(a_in_data), a_in_mode, a_in_tag, 32));
            if (b_out_valid) begin
                cmp("b", qb.size() != 0, int'(b_out_count), b_out_zero,
                    b_out_tag, qb.size() != 0 ? qb[0] : dummy);
                if (b_out_ready && qb.size() != 0) begin
                    nb++;
                    void'(qb.pop_front());
                end
            end
            if (b_in_valid && b_in_ready)
                qb.push_back(mk(64'(b_in_data), b_in_mode, b_in_tag, 8));
            if (c_out_valid) begin
                cmp("c", qc.size() != 0, int'(c_out_count), c_out_zero,
                    c_out_tag, qc.size() != 0 ? qc[0] : dummy);
                if (c_out_ready && qc.size() != 0) begin
                    nc++;
                    void'(qc.pop_front());
                end
            end
            if (c_in_valid && c_in_ready)
                qc.push_back(mk(c_in_data, c_in_mode, c_in_tag, 64));
        end
    end

    task automatic sweep_b();
        for (int n = 0; n < 300; n++) begin
            case (n % 4)
                0: b_in_data = 8'($urandom);
                1: b_in_data = 8'(1) << $urandom_range(7, 0);
                2: b_in_data = '0;
                default: b_in_data = '1;
            endcase
            b_in_mode   = 1'($urandom_range(1, 0));
            b_in_tag    = 4'($urandom);
            b_in_valid  = ($urandom_range(3, 0) != 0);
            b_out_ready = ($urandom_range(3, 0) != 0);
            @(posedge clk); #1;
        end
        b_in_valid  = 0;
        b_out_ready = 1;
    endtask

    task automatic sweep_c();
        for (int n = 0; n < 300; n++) begin
            case (n % 4)
                0: c_in_data = {$urandom, $urandom} >> $urandom_range(63, 0);
                1: c_in_data = 64'(1) << $urandom_range(63, 0);
                2: c_in_data = '0;
                default: c_in_data = '1;
            endcase
            c_in_mode   = 1'($urandom_range(1, 0));
            c_in_tag    = 4'($urandom);
            c_in_valid  = ($urandom_range(3, 0) != 0);
            c_out_ready = ($urandom_range(3, 0) != 0);
            @(posedge clk); #1;
        end
        c_in_valid  = 0;
        c_out_ready = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        chk("model_00f0", ref_lzc(64'h00F0_0000, 0, 32), 8);
        chk("model_f0_m1", ref_lzc(64'hF0, 1, 8), 4);
        chk("model_one64", ref_lzc(64'h1, 0, 64), 63);
        chk("model_ones_m1", ref_lzc(64'hFFFF_FFFF, 1, 32), 32);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(a_in_ready), 0);
        chk("rst_out_valid", int'(a_out_valid), 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("post_rst_in_ready", int'(a_in_ready), 1);
        chk("post_rst_valid", int'(a_out_valid), 0);
        chk("post_rst_count", int'(a_out_count), 0);
        chk("post_rst_zero", int'(a_out_zero), 0);
        chk("post_rst_tag", int'(a_out_tag), 0);
        @(posedge clk); #1;

        // Back-to-back stream: result n appears two cycles after offer n
        for (int n = 0; n < 9; n++) begin
            a_in_valid = (n < 6);
            if (n < 6) begin
                a_in_data = v_d[n];
                a_in_mode = v_m[n];
                a_in_tag  = 4'(n);
            end
            @(negedge clk);
            if (n >= 2 && n < 8) begin
                chk("stream_valid", int'(a_out_valid), 1);
                chk("stream_count", int'(a_out_count), v_c[n-2]);
                chk("stream_zero", int'(a_out_zero), int'(v_z[n-2]));
            end else begin
                chk("stream_idle", int'(a_out_valid), 0);
            end
            @(posedge clk); #1;
        end

        log_a.delete();
        a_out_ready = 0;
        a_in_mode   = 0;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            a_in_valid = 1;
            a_in_data  = t3_d[k];
            a_in_tag   = 4'(k + 1);
            @(negedge clk);
            if (a_in_ready) k++;
            @(posedge clk); #1;
        end
        chk("bp_accepts", k, 2);
        chk("bp_in_ready_low", int'(a_in_ready), 0);
        chk("bp_hold_tag", int'(a_out_tag), 1);
        chk("bp_hold_count", int'(a_out_count), 16);

        a_out_ready = 1;
        for (int c = 0; c < 8; c++) begin
            a_in_valid = (k < 4);
            if (k < 4) begin
                a_in_data = t3_d[k];
                a_in_tag  = 4'(k + 1);
            end
            @(negedge clk);
            if (c == 0) chk("full_in_ready", int'(a_in_ready), 1);
            if (c < 4) chk("no_bubble", int'(a_out_valid), 1);
            if (a_in_valid && a_in_ready) k++;
            @(posedge clk); #1;
        end
        chk("bp_all_accepted", k, 4);
        chk("bp_emitted", log_a.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("bp_order", int'(log_a[i]), i + 1);

        a_out_ready = 0;
        a_in_valid  = 1;
        a_in_data   = 32'h0001_0000;
        a_in_tag    = 4'd9;
        @(posedge clk); #1;
        a_in_tag    = 4'd10;
        @(posedge clk); #1;
        a_in_valid  = 0;
        rst         = 1;
        @(negedge clk);
        chk("flush_in_ready", int'(a_in_ready), 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("flush_valid", int'(a_out_valid), 0);
        chk("flush_count", int'(a_out_count), 0);
        chk("flush_zero", int'(a_out_zero), 0);
        chk("flush_tag", int'(a_out_tag), 0);
        chk("flush_in_ready_up", int'(a_in_ready), 1);
        @(posedge clk); #1;
        log_a.delete();
        a_out_ready = 1;
        a_in_valid  = 1;
        a_in_data   = 32'h0000_0100;
        a_in_tag    = 4'd5;
        @(negedge clk);
        chk("new_lat0", int'(a_out_valid), 0);
        @(posedge clk); #1;
        a_in_valid = 0;
        @(negedge clk);
        chk("new_lat1", int'(a_out_valid), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("new_valid", int'(a_out_valid), 1);
        chk("new_count", int'(a_out_count), 23);
        chk("new_tag", int'(a_out_tag), 5);
        repeat (4) @(posedge clk);
        #1;
        chk("flush_emitted", log_a.size(), 1);

        fork
            sweep_b();
            sweep_c();
        join
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("b_drained", qb.size(), 0);
        chk("c_drained", qc.size(), 0);
        chk("b_traffic", int'(nb > 50), 1);
        chk("c_traffic", int'(nc > 50), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lzc_dichotomy_pipe.md
Name: lzc_dichotomy_pipe

Overview:
- Parametrised, pipelined leading-zero / leading-one counter using binary dichotomy: an OR-reduce and select tree, log2(WIDTH) levels.
- Generalises the fixed 8-bit combinational LZC used by the normalisation paths to any power-of-two width.
- Adds an explicit all-zero flag, a leading-ones mode, configurable register stages, a valid/ready handshake with backpressure, and a pass-through tag.
- Sits between the mantissa datapath and the normalisation shifter.

Parameters:
- WIDTH, 32, input word width; power of two, 4..256.
- PIPE_STAGES, 2, register stages; 1..log2(WIDTH). Tree levels are split as evenly as possible, with earlier stages taking any extra level.
- TAG_W, 4, width of the sideband tag carried alongside each word.
- CNT_W, $clog2(WIDTH)+1, derived count width; not to be overridden.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  word to count; bit WIDTH-1 is the MSB.
- in_mode  input  1  0 = count leading zeros, 1 = count leading ones.
- in_tag  input  TAG_W  sideband tag, returned unchanged.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_count  output  CNT_W  count of leading zeros (or ones), range 0..WIDTH.
- out_zero  output  1  no bit of the counted polarity found; set when the word is all-0 (mode 0) or all-1 (mode 1).
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- Reset: one synchronous, active-high reset on clk. While rst=1 at a clock edge:
  - all stage valid bits clear; out_valid=0;
  - out_count=0, out_zero=0, out_tag=0;
  - in_ready=0 during reset, 1 on the first cycle after reset.
  - Words in flight when reset is asserted are discarded; nothing is emitted for them.
- Transfers:
  - Input transfer when in_valid & in_ready at a rising edge.
  - Output transfer when out_valid & out_ready.
- Mode handling: mode 1 inverts in_data at entry, and the tree always searches for the first 1 from the MSB.
- Dichotomy tree, level k (k=1..log2 WIDTH):
  - Splits the current window in half.
  - Count bit (log2 WIDTH - k) = NOT(OR of upper half).
  - Selects the upper half if it is non-zero, else the lower half.
- Count encoding:
  - out_count[CNT_W-2:0] = WIDTH-1-(index of first set bit).
  - All-zero window: out_count = WIDTH (MSB set, other bits 0) and out_zero=1; otherwise out_zero=0 and the count MSB is 0.
- Pipeline:
  - Each stage register holds partial count bits, the remaining window, the tag and a valid bit.
  - Latency is exactly PIPE_STAGES cycles from input transfer to out_valid when out_ready stays high.
  - Throughput is 1 word per cycle.
- Elastic stall:
  - stage_i advances when its successor is empty or advancing.
  - The last stage advances on out_ready.
  - in_ready = ~stage0_valid | stage0_advance. The ready chain is combinational backward; there are no skid buffers.
- Ordering and integrity:
  - Capacity is PIPE_STAGES words.
  - Strict FIFO order; no drop and no duplication.
  - While out_valid=1 and out_ready=0: out_count, out_zero and out_tag hold stable.
- Simultaneous events: with a full pipe, out_ready=1 and in_valid=1 in the same cycle, the block accepts and emits in that cycle (in_ready=1).
- Inputs outside a transfer are ignored. in_mode is sampled only at input transfer.

Test Plan:
1. WIDTH=32, PIPE_STAGES=2, out_ready=1; inputs 0x8000_0000, 0x0000_0001, 0x00F0_0000, mode 0, back-to-back:
   - expect counts 0, 31, 8 with zero=0;
   - first result on cycle +2, then one per cycle, in order.
2. Input 0x0000_0000, mode 0 -> count=32, zero=1. Input 0xFFFF_FFFF, mode 1 -> count=32, zero=1. Input 0xFFFF_0000, mode 1 -> count=16, zero=0.
3. Backpressure: hold out_ready=0 while offering 4 words with tags 1..4:
   - in_ready falls after 2 accepts;
   - outputs remain stable while stalled;
   - releasing out_ready yields tags 1,2,3,4 in order with correct counts.
4. Full pipe with out_ready=1 and in_valid=1 in the same cycle: in_ready=1; one result emitted and one word accepted that cycle, with no bubble.
5. Assert rst for 1 cycle with 2 words in flight:
   - out_valid=0 and outputs zeroed the next cycle;
   - the flushed words are never emitted;
   - a new word 0x0000_0100 yields count=23.
6. Randomised sweep at WIDTH=8, PIPE_STAGES=1 and WIDTH=64, PIPE_STAGES=6: every output matches a reference count loop, including single-bit and all-zero words.
